// File: rtl/mem_pkg.sv
// Shared encodings for the memory access controller, its load-extension helper
// and any RAM model that talks to it.
package mem_pkg;

  typedef enum logic [1:0] {
    MODE_BYTE     = 2'b00,
    MODE_HALFWORD = 2'b01,
    MODE_WORD     = 2'b10,
    MODE_ILLEGAL  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COMPLETE,
    ST_ABORT
  } state_e;

  localparam logic [1:0] ABORT_NONE       = 2'b00;
  localparam logic [1:0] ABORT_MISALIGNED = 2'b01;
  localparam logic [1:0] ABORT_TIMEOUT    = 2'b10;
  localparam logic [1:0] ABORT_ILLEGAL    = 2'b11;

  // Only the two low address bits matter for natural alignment.
  function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] addr_lsb);
    return ((mode == MODE_HALFWORD) && addr_lsb[0]) ||
           ((mode == MODE_WORD) && (addr_lsb != 2'b00));
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] mode);
    logic [3:0] mask;
    case (mode)
      MODE_BYTE:     mask = 4'b0001;
      MODE_HALFWORD: mask = 4'b0011;
      MODE_WORD:     mask = 4'b1111;
      default:       mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_extend.sv
// Zero/sign extension of right-justified RAM read data to a full 32-bit load result.
module mem_extend
  import mem_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic        signed_ld,
  input  logic [31:0] q,
  output logic [31:0] ext_word
);

  always_comb begin
    ext_word = q;
    case (mode)
      MODE_BYTE:     ext_word = {{24{signed_ld & q[7]}}, q[7:0]};
      MODE_HALFWORD: ext_word = {{16{signed_ld & q[15]}}, q[15:0]};
      default:       ext_word = q;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side memory access sequencer: validates a request, drives one RAM access,
// waits for operation-complete with a timeout and returns an extended load result.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  mode,
  input  logic        signed_ld,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic [1:0]  abort_code,
  output logic [31:0] rdata,
  output logic        ram_enable,
  output logic        ram_w_r,
  output logic [1:0]  ram_mode,
  output logic [7:0]  ram_address,
  output logic [31:0] ram_data,
  input  logic        ram_moc,
  input  logic [31:0] ram_q
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_e      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        abort_reg;
  logic [1:0]  abort_code_reg;
  logic [31:0] rdata_reg;
  logic        ram_enable_reg;
  logic        rw_reg;
  logic [1:0]  mode_reg;
  logic        signed_reg;
  logic [7:0]  addr_reg;
  logic [31:0] data_reg;

  logic [3:0]  lane_en;
  logic [31:0] store_data;
  logic [31:0] load_ext;

  // Reads carry no store data; writes keep only the lanes the access size covers.
  assign lane_en = rw ? 4'b0000 : lane_mask(mode);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign store_data[8*gi +: 8] = lane_en[gi] ? wdata[8*gi +: 8] : 8'h00;
  end

  mem_extend u_extend (
    .mode      (mode_reg),
    .signed_ld (signed_reg),
    .q         (ram_q),
    .ext_word  (load_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      wait_cnt_reg   <= 4'd0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      abort_reg      <= 1'b0;
      abort_code_reg <= ABORT_NONE;
      rdata_reg      <= 32'd0;
      ram_enable_reg <= 1'b0;
      rw_reg         <= 1'b1;
      mode_reg       <= MODE_BYTE;
      signed_reg     <= 1'b0;
      addr_reg       <= 8'h00;
      data_reg       <= 32'd0;
    end else begin
      done_reg  <= 1'b0;
      abort_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            rw_reg     <= rw;
            mode_reg   <= mode;
            signed_reg <= signed_ld;
            addr_reg   <= addr;
            data_reg   <= store_data;
            busy_reg   <= 1'b1;
            if (mode == MODE_ILLEGAL) begin
              state_reg      <= ST_ABORT;
              abort_reg      <= 1'b1;
              abort_code_reg <= ABORT_ILLEGAL;
            end else if (is_misaligned(mode, addr[1:0])) begin
              state_reg      <= ST_ABORT;
              abort_reg      <= 1'b1;
              abort_code_reg <= ABORT_MISALIGNED;
            end else begin
              state_reg      <= ST_ISSUE;
              ram_enable_reg <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt_reg <= 4'd0;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + 4'd1;
          // Completion is checked first so a strobe on the last allowed cycle still succeeds.
          if (ram_moc) begin
            if (rw_reg) begin
              rdata_reg <= load_ext;
            end
            state_reg      <= ST_COMPLETE;
            done_reg       <= 1'b1;
            ram_enable_reg <= 1'b0;
          end else if (wait_cnt_reg == TIMEOUT_CNT) begin
            state_reg      <= ST_ABORT;
            abort_reg      <= 1'b1;
            abort_code_reg <= ABORT_TIMEOUT;
            ram_enable_reg <= 1'b0;
          end
        end
        ST_COMPLETE, ST_ABORT: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg      <= ST_IDLE;
          busy_reg       <= 1'b0;
          ram_enable_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign abort       = abort_reg;
  assign abort_code  = abort_code_reg;
  assign rdata       = rdata_reg;
  assign ram_enable  = ram_enable_reg;
  assign ram_w_r     = rw_reg;
  assign ram_mode    = mode_reg;
  assign ram_address = addr_reg;
  assign ram_data    = data_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a timeline model of each access plus a byte-array RAM.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        signed_ld = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'd0;
  logic        ram_moc = 1'b0;
  logic [31:0] ram_q = 32'd0;
  logic        busy, done, abort, ram_enable, ram_w_r;
  logic [1:0]  abort_code, ram_mode;
  logic [7:0]  ram_address;
  logic [31:0] rdata, ram_data;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .mode(mode), .signed_ld(signed_ld),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .abort(abort),
    .abort_code(abort_code), .rdata(rdata), .ram_enable(ram_enable), .ram_w_r(ram_w_r),
    .ram_mode(ram_mode), .ram_address(ram_address), .ram_data(ram_data),
    .ram_moc(ram_moc), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs for the current cycle, written by the stimulus just after each edge.
  logic        e_busy, e_done, e_abort, e_ram_enable, e_ram_w_r;
  logic [1:0]  e_code, e_ram_mode;
  logic [7:0]  e_addr;
  logic [31:0] e_rdata, e_ram_data;
  logic        check_en = 1'b0;

  logic [7:0]  mem [256];

  int   en_rises = 0;
  int   en_rise_cyc = 0;
  int   en_fall_cyc = 0;
  int   last_gap = 0;
  int   done_cyc = -1;
  int   abort_cyc = -1;
  logic en_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy",        32'(busy),        32'(e_busy));
      chk("done",        32'(done),        32'(e_done));
      chk("abort",       32'(abort),       32'(e_abort));
      chk("abort_code",  32'(abort_code),  32'(e_code));
      chk("rdata",       rdata,            e_rdata);
      chk("ram_enable",  32'(ram_enable),  32'(e_ram_enable));
      chk("ram_w_r",     32'(ram_w_r),     32'(e_ram_w_r));
      chk("ram_mode",    32'(ram_mode),    32'(e_ram_mode));
      chk("ram_address", 32'(ram_address), 32'(e_addr));
      chk("ram_data",    ram_data,         e_ram_data);
    end
    if (ram_enable && !en_prev) begin
      en_rises++;
      last_gap = cyc - en_fall_cyc;
      en_rise_cyc = cyc;
    end
    if (!ram_enable && en_prev) en_fall_cyc = cyc;
    en_prev = ram_enable;
    if (done) done_cyc = cyc;
    if (abort) abort_cyc = cyc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reset_exp();
    e_busy = 0; e_done = 0; e_abort = 0; e_code = 2'b00; e_rdata = 32'd0;
    e_ram_enable = 0; e_ram_w_r = 1; e_ram_mode = 2'b00; e_addr = 8'h00; e_ram_data = 32'd0;
  endtask

  function automatic int nbytes(input logic [1:0] m);
    return (m == MODE_BYTE) ? 1 : (m == MODE_HALFWORD) ? 2 : 4;
  endfunction

  function automatic logic [31:0] store_mask(input logic [1:0] m, input logic [31:0] wd);
    if (m == MODE_BYTE) return wd & 32'h0000_00FF;
    if (m == MODE_HALFWORD) return wd & 32'h0000_FFFF;
    if (m == MODE_WORD) return wd;
    return 32'd0;
  endfunction

  // RAM returns the addressed bytes right-justified, with junk above them.
  function automatic logic [31:0] ram_read(input logic [1:0] m, input logic [7:0] a);
    logic [31:0] q;
    q = $urandom;
    for (int i = 0; i < nbytes(m); i++) q[8*i +: 8] = mem[8'(a + 8'(i))];
    return q;
  endfunction

  function automatic logic [31:0] load_value(input logic [1:0] m, input logic s, input logic [31:0] q);
    logic [31:0] v, lim;
    if (nbytes(m) == 4) return q;
    lim = 32'd1 << (8 * nbytes(m));
    v = q & (lim - 32'd1);
    if (s && (v >= (lim >> 1))) v = v - lim;
    return v;
  endfunction

  // One request from IDLE back to IDLE. moc_at = WAIT cycle of the RAM strobe (0 = never).
  task automatic do_access(input logic r, input logic [1:0] m, input logic s, input logic [7:0] a,
                           input logic [31:0] wd, input int moc_at, input logic hold,
                           output int req_c);
    logic [1:0]  code;
    logic [31:0] q;
    int          n;
    bit          fin;
    rw = r; mode = m; signed_ld = s; addr = a; wdata = wd; req = 1'b1;
    req_c = cyc;
    code = ABORT_NONE;
    if (m == MODE_ILLEGAL) code = ABORT_ILLEGAL;
    else if ((m == MODE_HALFWORD && a[0]) || (m == MODE_WORD && a[1:0] != 2'b00)) code = ABORT_MISALIGNED;
    q = 32'd0;
    step();
    if (!hold) req = 1'b0;
    e_busy = 1; e_ram_w_r = r; e_ram_mode = m; e_addr = a;
    e_ram_data = r ? 32'd0 : store_mask(m, wd);
    if (code != ABORT_NONE) begin
      e_abort = 1; e_code = code;
      step();
      e_abort = 0; e_busy = 0;
    end else begin
      e_ram_enable = 1;
      n = 0; fin = 0;
      while (!fin) begin
        step();
        n++;
        if (n == moc_at) begin
          ram_moc = 1'b1;
          q = ram_read(m, a);
          ram_q = q;
        end
        if (n == moc_at || n == TIMEOUT + 1) fin = 1;
      end
      step();
      ram_moc = 1'b0; ram_q = $urandom;
      e_ram_enable = 0;
      if (n == moc_at) begin
        e_done = 1;
        if (r) e_rdata = load_value(m, s, q);
        else for (int i = 0; i < nbytes(m); i++) mem[8'(a + 8'(i))] = wd[8*i +: 8];
      end else begin
        e_abort = 1; e_code = ABORT_TIMEOUT;
      end
      step();
      e_done = 0; e_abort = 0; e_busy = 0;
    end
    $display("[TB] txn %s mode=%0d signed=%0d addr=0x%02h wdata=0x%08h moc_at=%0d -> rdata=0x%08h code=%0d",
             r ? "RD" : "WR", m, s, a, wd, moc_at, rdata, abort_code);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rc, rises0, dc0, ac0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[5] = 8'h80;
    set_reset_exp();
    rst_n = 1'b0;
    step(); step();
    check_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("reset_rdata_lit", rdata, 32'd0);

    // Signed and unsigned byte loads of 0x80, one-cycle strobe.
    do_access(1'b1, MODE_BYTE, 1'b1, 8'h05, 32'd0, 1, 1'b0, rc);
    chk("byte_signed_lit", rdata, 32'hFFFF_FF80);
    chk("done_latency_lit", 32'(done_cyc - rc), 32'd3);
    do_access(1'b1, MODE_BYTE, 1'b0, 8'h05, 32'd0, 1, 1'b0, rc);
    chk("byte_unsigned_lit", rdata, 32'h0000_0080);

    // Misaligned halfword never touches the RAM.
    rises0 = en_rises;
    do_access(1'b1, MODE_HALFWORD, 1'b0, 8'h03, 32'd0, 1, 1'b0, rc);
    chk("misalign_code_lit", 32'(abort_code), 32'h1);
    chk("misalign_no_enable", 32'(en_rises - rises0), 32'd0);
    do_access(1'b0, MODE_WORD, 1'b0, 8'h06, 32'h1111_2222, 1, 1'b0, rc);
    do_access(1'b1, MODE_ILLEGAL, 1'b0, 8'h00, 32'd0, 1, 1'b0, rc);
    chk("illegal_code_lit", 32'(abort_code), 32'h3);

    // Word write then word read back-to-back.
    do_access(1'b0, MODE_WORD, 1'b0, 8'h08, 32'hDEAD_BEEF, 2, 1'b0, rc);
    do_access(1'b1, MODE_WORD, 1'b0, 8'h08, 32'd0, 3, 1'b0, rc);
    chk("word_readback_lit", rdata, 32'hDEAD_BEEF);
    chk("enable_gap_ge2", 32'(last_gap >= 2), 32'd1);

    // Timeout, then a normal halfword read of the 0xBEEF half.
    do_access(1'b1, MODE_WORD, 1'b0, 8'h20, 32'd0, 0, 1'b0, rc);
    chk("timeout_code_lit", 32'(abort_code), 32'h2);
    chk("timeout_cycles_lit", 32'(abort_cyc - (en_rise_cyc + 1)), 32'd16);
    do_access(1'b1, MODE_HALFWORD, 1'b1, 8'h08, 32'd0, 2, 1'b0, rc);
    chk("half_signed_lit", rdata, 32'hFFFF_BEEF);

    // Strobe on the very last WAIT cycle still completes.
    do_access(1'b1, MODE_BYTE, 1'b0, 8'h0B, 32'd0, TIMEOUT + 1, 1'b0, rc);
    chk("moc_wins_lit", rdata, 32'h0000_00DE);

    // Narrow writes, top-of-memory byte, and a write leaving rdata alone.
    do_access(1'b0, MODE_BYTE, 1'b0, 8'hFF, 32'hA5A5_A55A, 1, 1'b0, rc);
    do_access(1'b0, MODE_HALFWORD, 1'b0, 8'h0E, 32'h1234_8678, 4, 1'b0, rc);
    chk("write_keeps_rdata_lit", rdata, 32'h0000_00DE);
    do_access(1'b1, MODE_BYTE, 1'b1, 8'hFF, 32'd0, 2, 1'b0, rc);
    chk("top_byte_lit", rdata, 32'h0000_005A);
    do_access(1'b1, MODE_HALFWORD, 1'b1, 8'h0E, 32'd0, 1, 1'b0, rc);
    chk("half_neg_lit", rdata, 32'hFFFF_8678);

    // req held high: one access per IDLE visit.
    rises0 = en_rises;
    do_access(1'b0, MODE_WORD, 1'b0, 8'h40, 32'hCAFE_F00D, 2, 1'b1, rc);
    do_access(1'b0, MODE_WORD, 1'b0, 8'h40, 32'hCAFE_F00D, 2, 1'b0, rc);
    chk("held_req_two_accesses", 32'(en_rises - rises0), 32'd2);

    // Reset in WAIT, then a late strobe.
    dc0 = done_cyc; ac0 = abort_cyc;
    rw = 1'b1; mode = MODE_WORD; signed_ld = 1'b0; addr = 8'h10; wdata = 32'd0; req = 1'b1;
    step();
    req = 1'b0;
    e_busy = 1; e_ram_enable = 1; e_ram_w_r = 1; e_ram_mode = MODE_WORD; e_addr = 8'h10; e_ram_data = 32'd0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    set_reset_exp();
    rst_n = 1'b1; ram_moc = 1'b1; ram_q = 32'h1234_5678;
    step();
    ram_moc = 1'b0;
    step(); step();
    chk("no_done_after_reset", 32'(done_cyc - dc0), 32'd0);
    chk("no_abort_after_reset", 32'(abort_cyc - ac0), 32'd0);
    $display("[TB] txn RD mode=2 addr=0x10 reset during WAIT, late moc ignored -> rdata=0x%08h", rdata);

    do_access(1'b1, MODE_WORD, 1'b0, 8'h40, 32'd0, 1, 1'b0, rc);
    chk("after_reset_read_lit", rdata, 32'hCAFE_F00D);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, means the maximum cycles spent waiting for ram_moc before abort.
REQ-002 clk  in  1  single clock; all logic SHALL be sampled on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req  in  1  CPU access request, sampled in IDLE only.
REQ-005 rw  in  1  1=read, 0=write.
REQ-006 mode  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 signed_ld  in  1  on reads, 1=sign-extend byte/halfword, 0=zero-extend.
REQ-008 addr  in  8  byte address.
REQ-009 wdata  in  32  store data, right-justified.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse on successful completion.
REQ-012 abort  out  1  one-cycle pulse on failed request.
REQ-013 abort_code  out  2  01 misaligned, 10 timeout, 11 illegal mode; valid with abort, held until next abort.
REQ-014 rdata  out  32  extended load result.
REQ-015 ram_enable, ram_w_r, ram_mode[1:0], ram_address[7:0], ram_data[31:0]  out  drive the RAM enable, read/write, access mode, address and data ports.
REQ-016 ram_moc  in  1  RAM operation-complete strobe; ram_q  in  32  RAM read data.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT, COMPLETE and ABORT.
REQ-018 In IDLE with req=1, the block SHALL latch rw, mode, signed_ld, addr and wdata into internal registers.
REQ-019 Latched values SHALL drive the ram_* outputs unchanged until the FSM returns to IDLE.
REQ-020 In IDLE with req=1, mode=11 SHALL go to ABORT with code 11.
REQ-021 In IDLE with req=1, halfword with addr[0]=1 or word with addr[1:0]!=00 SHALL go to ABORT with code 01.
REQ-022 In IDLE with req=1, any other request SHALL go to ISSUE.
REQ-023 ISSUE SHALL assert ram_enable, clear the wait counter and go to WAIT on the next cycle.
REQ-024 ram_enable SHALL stay high throughout ISSUE and WAIT and be low in every other state.
REQ-025 WAIT SHALL increment the 4-bit wait counter each cycle.
REQ-026 WAIT with ram_moc=1 SHALL capture ram_q (reads only) and go to COMPLETE; ram_moc SHALL win over a simultaneous timeout.
REQ-027 WAIT with counter=TIMEOUT and ram_moc=0 SHALL go to ABORT with code 10.
REQ-028 COMPLETE SHALL pulse done for one cycle and go to IDLE.
REQ-029 ABORT SHALL pulse abort for one cycle, leave rdata unchanged and go to IDLE.
REQ-030 Latency SHALL be as follows: req sampled at cycle 0, ISSUE at cycle 1, ram_moc seen at WAIT cycle n (n>=1), done at cycle n+2.
REQ-031 ram_enable SHALL be low for at least 2 cycles between consecutive accesses, guaranteeing a fresh RAM rising edge.
REQ-032 req asserted while busy=1 SHALL be ignored, not queued.
REQ-033 Byte read rdata SHALL be ram_q[7:0] extended to 32 bits per signed_ld.
REQ-034 Halfword read rdata SHALL be ram_q[15:0] extended to 32 bits per signed_ld.
REQ-035 Word read rdata SHALL be ram_q.
REQ-036 rdata SHALL hold its value until the next completed read; writes SHALL not alter it.
REQ-037 Byte writes SHALL put wdata[7:0] on ram_data[7:0]; halfword writes SHALL put wdata[15:0] on ram_data[15:0]; unused ram_data bits SHALL be zero.
REQ-038 Address arithmetic SHALL be 8-bit; the alignment checks prevent multi-byte accesses from wrapping past 0xFF.

Reset
REQ-039 With rst_n=0 at a rising clk edge, the FSM SHALL go to IDLE from any state, including mid-WAIT.
REQ-040 Reset SHALL set busy, done, abort, ram_enable and the wait counter to 0, set abort_code to 00 and rdata to 0.
REQ-041 Reset SHALL drive ram_w_r=1 (read, harmless), ram_mode=00, ram_address=0x00 and ram_data=0.
REQ-042 A ram_moc arriving after reset SHALL be ignored.

Structure
REQ-043 A shared package mem_pkg SHALL hold the mode encodings (BYTE, HALFWORD, WORD), the FSM state type and the abort-code constants; the RAM model SHALL reuse the mode encodings.
REQ-044 A single combinational sub-module mem_extend (inputs mode, signed_ld, q; output extended word) SHALL implement REQ-033 to REQ-035.

Verification
REQ-045 Byte read at 0x05 (RAM byte 0x80), signed_ld=1 -> rdata=0xFFFFFF80, done 3 cycles after req with 1-cycle moc; with signed_ld=0 -> 0x00000080.
REQ-046 Halfword read at 0x03 -> abort=1, abort_code=01, ram_enable never asserted.
REQ-047 Word write 0xDEADBEEF at 0x08, then word read at 0x08 -> rdata=0xDEADBEEF, ram_enable low >=2 cycles between the two accesses.
REQ-048 RAM model never returns moc -> abort with code 10 exactly TIMEOUT+1 cycles after entering WAIT; next request proceeds normally.
REQ-049 rst_n=0 during WAIT, then a late moc -> outputs at reset values, no done pulse.
REQ-050 req held high across a full access -> exactly one access per IDLE visit, second req ignored while busy=1.
